// File: rtl/nn_avalon_pkg.sv
// nn_avalon_pkg: burst-master state encoding, Avalon response codes and default bus widths
// shared with the accelerator slave.
package nn_avalon_pkg;
    typedef enum logic [2:0] {IDLE, WR_BURST, RD_CMD, RD_DATA, FINISH} state_t;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECODEERROR = 2'b11;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int BCOUNT_W = 10;
endpackage

// File: rtl/nn_avm_watchdog.sv
// nn_avm_watchdog: counts stalled cycles of an active burst and flags expiry.
module nn_avm_watchdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic kick,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;
    assign expired = active && cnt == CW'(TIMEOUT_CYC);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else cnt <= (!active || kick) ? '0 : expired ? cnt : cnt + CW'(1);
endmodule

// File: rtl/nn_avalon_burst_master.sv
// nn_avalon_burst_master: one-command-at-a-time Avalon-MM burst write/read initiator.
// Define NN_AVM_TIMEOUT_EN to abort bursts that stall for TIMEOUT_CYC cycles.
module nn_avalon_burst_master #(
    parameter int ADDR_W      = nn_avalon_pkg::ADDR_W,
    parameter int DATA_W      = nn_avalon_pkg::DATA_W,
    parameter int BCOUNT_W    = nn_avalon_pkg::BCOUNT_W,
    parameter int MAX_BURST   = 512,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [BCOUNT_W-1:0] cmd_len,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_write,
    output logic                avm_read,
    output logic                avm_beginbursttransfer,
    output logic [BCOUNT_W-1:0] avm_burstcount,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid,
    input  logic                avm_waitrequest,
    input  logic [1:0]          avm_response
);
    import nn_avalon_pkg::*;

    state_t state, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [BCOUNT_W-1:0] len_q, cnt;
    logic accept, bad, last, wr_beat, rd_beat, on_bus, expired;

    assign accept  = cmd_valid && cmd_ready;
    assign bad     = cmd_len == '0 || 32'(cmd_len) > MAX_BURST;
    assign last    = cnt + BCOUNT_W'(1) == len_q;
    assign wr_beat = avm_write && !avm_waitrequest;
    assign rd_beat = state == RD_DATA && avm_readdatavalid && !expired;
    assign on_bus  = state == WR_BURST || state == RD_CMD;

`ifdef NN_AVM_TIMEOUT_EN
    nn_avm_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
        .clk,
        .rst,
        .active (on_bus || state == RD_DATA),
        .kick   (wr_beat || (avm_read && !avm_waitrequest) || (state == RD_DATA && avm_readdatavalid)),
        .expired(expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d        = state;
        cmd_ready      = state == IDLE;
        avm_write      = state == WR_BURST && wr_valid && !expired;
        wr_ready       = avm_write && !avm_waitrequest;
        avm_writedata  = state == WR_BURST ? wr_data : '0;
        avm_read       = state == RD_CMD && !expired;
        avm_address    = on_bus ? addr_q : '0;
        avm_burstcount = on_bus ? len_q : '0;
        done           = state == FINISH;
        case (state)
            IDLE:     state_d = !cmd_valid ? IDLE : bad ? FINISH : cmd_write ? WR_BURST : RD_CMD;
            WR_BURST: state_d = (expired || (wr_beat && last)) ? FINISH : WR_BURST;
            RD_CMD:   state_d = expired ? FINISH : !avm_waitrequest ? RD_DATA : RD_CMD;
            RD_DATA:  state_d = (expired || (rd_beat && last)) ? FINISH : RD_DATA;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state                  <= IDLE;
            addr_q                 <= '0;
            len_q                  <= '0;
            cnt                    <= '0;
            err                    <= 1'b0;
            rd_data                <= '0;
            rd_valid               <= 1'b0;
            avm_beginbursttransfer <= 1'b0;
        end else begin
            state                  <= state_d;
            avm_beginbursttransfer <= accept && !bad;
            rd_valid               <= rd_beat;
            if (rd_beat) rd_data <= avm_readdata;
            if (accept) begin
                addr_q <= cmd_addr;
                len_q  <= cmd_len;
                cnt    <= '0;
                err    <= bad;
            end else begin
                if (wr_beat || rd_beat) cnt <= cnt + BCOUNT_W'(1);
                // error responses are sticky; later beats are still collected
                if ((rd_beat && avm_response != RESP_OKAY) || expired) err <= 1'b1;
            end
        end
endmodule

// File: tb/tb_nn_avalon_burst_master.sv
// tb_nn_avalon_burst_master: randomized scoreboard bench with a behavioural Avalon slave
// and write-data source; expected beats and completions are queued when commands are issued.
`timescale 1ns/1ps
module tb_nn_avalon_burst_master;
    import nn_avalon_pkg::*;
    localparam int AW = 13, DW = 32, BW = 10;

    logic clk = 0, rst = 1;
    logic cmd_valid = 0, cmd_write = 0, cmd_ready;
    logic [AW-1:0] cmd_addr = 0;
    logic [BW-1:0] cmd_len = 0;
    logic [DW-1:0] wr_data = 0;
    logic wr_valid = 0, wr_ready, rd_valid, done, err;
    logic [DW-1:0] rd_data, avm_writedata;
    logic [AW-1:0] avm_address;
    logic [BW-1:0] avm_burstcount;
    logic avm_write, avm_read, avm_beginbursttransfer;
    logic [DW-1:0] avm_readdata = 0;
    logic avm_readdatavalid = 0, avm_waitrequest = 0;
    logic [1:0] avm_response = 0;

    always #5 clk = ~clk;

    nn_avalon_burst_master #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
        .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
        .avm_beginbursttransfer(avm_beginbursttransfer), .avm_burstcount(avm_burstcount),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
        .avm_response(avm_response)
    );

    typedef struct {logic [DW-1:0] data; logic [1:0] resp;} beat_t;
    typedef struct {bit err; bit legal; bit chk_rd; bit chk_wr;} fin_t;

    logic [DW-1:0] wr_exp[$], rd_exp[$], wsrc[$];
    beat_t rd_src[$], pend[$];
    fin_t fin_q[$];
    beat_t sb;
    fin_t f;
    int checks = 0, errors = 0;
    int wait_pct = 0, rdv_pct = 100;
    bit stray = 0, took = 0, in_rd = 0, prev_rdv = 0, rd_acc_prev = 0;
    logic [AW-1:0] cur_addr = 0;
    logic [BW-1:0] cur_len = 0;
    int cyc = 0, bbt_cnt = 0, bus_cnt = 0, wcyc = 0, wcyc_done = 0, last_wb = 0, rv_cnt = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none (t=%0t)", name, $time);
    endtask

    // behavioural slave: random waitrequest, read beats returned with random gaps
    initial forever begin
        @(negedge clk);
        if (rst) pend.delete();
        else if (avm_read && !avm_waitrequest) begin
            pend = rd_src;
            rd_src.delete();
        end
        @(posedge clk);
        #1;
        avm_waitrequest = int'($urandom_range(0, 99)) < wait_pct;
        avm_readdatavalid = 0;
        if (pend.size() > 0 && int'($urandom_range(0, 99)) < rdv_pct) begin
            sb = pend.pop_front();
            avm_readdatavalid = 1;
            avm_readdata = sb.data;
            avm_response = sb.resp;
        end else if (stray) begin
            avm_readdatavalid = 1;
            avm_readdata = 32'hDEADBEEF;
            avm_response = RESP_SLVERR;
            stray = 0;
        end
    end

    // write-data source: holds each word stable until wr_ready
    initial forever begin
        @(negedge clk);
        took = wr_valid && wr_ready;
        @(posedge clk);
        #1;
        if (took && wsrc.size() > 0) void'(wsrc.pop_front());
        if (wsrc.size() > 0 && ((wr_valid && !took) || $urandom_range(0, 3) != 0)) begin
            wr_valid = 1;
            wr_data = wsrc[0];
        end else wr_valid = 0;
    end

    // monitor / scoreboard
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            chk("reset_outputs", 64'({wr_ready, rd_valid, done, err, avm_write, avm_read,
                avm_beginbursttransfer, |avm_address, |avm_burstcount, |avm_writedata, |rd_data}), 64'(0));
            chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
            in_rd = 0; prev_rdv = 0; rd_acc_prev = 0; bbt_cnt = 0; bus_cnt = 0; wcyc = 0;
        end else begin
            if (avm_beginbursttransfer) bbt_cnt++;
            if (avm_write || avm_read) begin
                bus_cnt++;
                chk("avm_address", 64'(avm_address), 64'(cur_addr));
                chk("avm_burstcount", 64'(avm_burstcount), 64'(cur_len));
            end
            if (avm_write) wcyc++;
            chk("wr_ready", 64'(wr_ready), 64'(avm_write && !avm_waitrequest));
            if (avm_write && !avm_waitrequest) begin
                last_wb = cyc;
                if (wr_exp.size() == 0) fail("wr_unexpected_beat");
                else chk("wr_data", 64'(avm_writedata), 64'(wr_exp.pop_front()));
            end
            if (rd_acc_prev) chk("avm_read_deassert", 64'(avm_read), 64'(0));
            rd_acc_prev = avm_read && !avm_waitrequest;
            if (rd_valid) begin
                rv_cnt++;
                if (rd_exp.size() == 0) fail("rd_unexpected_beat");
                else chk("rd_data", 64'(rd_data), 64'(rd_exp.pop_front()));
            end
            if (done) begin
                if (fin_q.size() == 0) fail("done_unexpected");
                else begin
                    f = fin_q.pop_front();
                    chk("done_err", 64'(err), 64'(f.err));
                    chk("bbt_pulses", 64'(bbt_cnt), 64'(f.legal));
                    if (!f.legal) chk("illegal_bus_activity", 64'(bus_cnt), 64'(0));
                    if (f.chk_rd) chk("done_with_last_rd_valid", 64'(rd_valid), 64'(1));
                    if (f.chk_rd) chk("rd_beats_left", 64'(rd_exp.size()), 64'(0));
                    if (f.chk_wr) chk("done_after_last_wr", 64'(cyc - last_wb), 64'(1));
                    if (f.chk_wr) chk("wr_beats_left", 64'(wr_exp.size()), 64'(0));
                end
                wcyc_done = wcyc; wcyc = 0; bbt_cnt = 0; bus_cnt = 0; in_rd = 0;
            end
            chk("rd_valid_timing", 64'(rd_valid), 64'(prev_rdv));
            prev_rdv = avm_readdatavalid && in_rd;
            if (avm_read && !avm_waitrequest) in_rd = 1;
        end
    end

    task automatic issue(bit w, logic [AW-1:0] a, int len, logic [DW-1:0] base, logic [DW-1:0] step,
                         int eb, bit to);
        bit legal = len >= 1 && len <= 512;
        bit e = !legal || to;
        int n = 0;
        logic [DW-1:0] d;
        beat_t b;
        @(posedge clk);
        #1;
        for (int i = 0; i < len && legal; i++) begin
            d = base + step * DW'(i);
            if (w) begin
                wsrc.push_back(d);
                if (!to) wr_exp.push_back(d);
            end else begin
                b.data = d;
                b.resp = (i == eb) ? ($urandom_range(0, 1) != 0 ? RESP_SLVERR : RESP_DECODEERROR) : RESP_OKAY;
                if (i == eb) e = 1;
                rd_src.push_back(b);
                if (!to) rd_exp.push_back(d);
            end
        end
        fin_q.push_back('{e, legal, !w && legal && !to, w && legal && !to});
        cur_addr = a;
        cur_len = BW'(len);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = BW'(len);
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 50);
        if (!cmd_ready) fail("cmd_accept_timeout");
        @(posedge clk);
        #1;
        cmd_valid = 0;
        @(negedge clk);
        chk("err_on_accept", 64'(err), 64'(!legal));
        chk("cmd_ready_busy", 64'(cmd_ready), 64'(0));
    endtask

    task automatic wait_done();
        int n = 0;
        while (fin_q.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (fin_q.size() > 0) begin
            fail("done_timeout");
            fin_q.delete();
        end
    endtask

    initial begin
        int n, rv0, len, eb;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        wait_pct = 40;
        issue(1, 13'h010, 4, 32'hA0, 32'h1, -1, 0);
        wait_done();
        wait_pct = 60; rdv_pct = 33;
        issue(0, 13'h100, 3, 32'h11, 32'h11, -1, 0);
        wait_done();
        wait_pct = 20; rdv_pct = 70;
        issue(0, 13'h080, 2, 32'h1234, 32'h1111, 1, 0);
        wait_done();
        repeat (2) @(negedge clk);
        chk("err_sticky", 64'(err), 64'(1));
        issue(0, 13'h000, 0, 0, 0, -1, 0);
        wait_done();
        issue(1, 13'h000, 513, 0, 0, -1, 0);
        wait_done();
        for (int k = 0; k < 14; k++) begin
            len = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(513, 1023)))
                                              : int'($urandom_range(1, 16));
            eb = ($urandom_range(0, 2) == 0 && len >= 1) ? int'($urandom_range(0, len - 1)) : -1;
            wait_pct = $urandom_range(0, 60);
            rdv_pct = $urandom_range(30, 100);
            issue($urandom_range(0, 1) != 0, AW'($urandom), len, $urandom, $urandom, eb, 0);
            wait_done();
        end
        stray = 1;
        repeat (4) @(negedge clk);
        wait_pct = 0; rdv_pct = 50;
        issue(0, 13'h040, 8, 32'h5000, 32'h1, -1, 0);
        rv0 = rv_cnt;
        n = 0;
        while (rv_cnt - rv0 < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("beats_before_reset", 64'(rv_cnt - rv0), 64'(2));
        @(posedge clk);
        #1;
        rst = 1;
        rd_exp.delete(); fin_q.delete(); rd_src.delete();
        @(posedge clk);
        #1;
        rst = 0;
        repeat (4) @(negedge clk);
        chk("cmd_ready_after_reset", 64'(cmd_ready), 64'(1));
        wait_pct = 30; rdv_pct = 100;
        issue(1, 13'h1F0, 5, 32'hBEE0, 32'h3, -1, 0);
        wait_done();
`ifdef NN_AVM_TIMEOUT_EN
        wait_pct = 100;
        issue(1, 13'h222, 4, 32'h77, 32'h1, -1, 1);
        wait_done();
        chk("timeout_write_cycles", 64'(wcyc_done > 0 && wcyc_done <= 16), 64'(1));
        wsrc.delete();
        wait_pct = 0; rdv_pct = 0;
        issue(0, 13'h333, 2, 32'h99, 32'h1, -1, 1);
        wait_done();
        rv0 = rv_cnt;
        rdv_pct = 100;
        repeat (8) @(negedge clk);
        chk("late_rdv_ignored", 64'(rv_cnt - rv0), 64'(0));
`endif
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
